ex_muldiv: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage.
- Sits directly downstream of the EX operand-select muxes and consumes the final ALU operand 1 and operand 2 values.
- Runs multi-cycle M-extension ops in parallel with the single-cycle ALU.
- Raises busy so hazard control stalls IF/ID/EX until the result is written into EX/MEM.

---
 rtl/ex_muldiv.sv | 197 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : Iterative RV32M multiply/divide unit for the EX stage.
//            Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_fix  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    localparam logic [ITER_CNT_W-1:0] c_cnt_last = ITER_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]       c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]            r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [XLEN-1:0]       r_result;
    logic [2:0]            r_funct3;
    logic                  r_neg1;
    logic                  r_neg2;
    logic                  r_nofix;
    logic [ITER_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]       r_b;
    logic [2*XLEN-1:0]     r_acc;

    // Operand capture: signedness per op, magnitudes and special cases.
    logic            w_is_div;
    logic            w_s1_en;
    logic            w_s2_en;
    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_div0;
    logic            w_ovf;

    assign w_is_div = funct3[2];
    assign w_s1_en  = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    assign w_s2_en  = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    assign w_neg1   = w_s1_en & op1[XLEN-1];
    assign w_neg2   = w_s2_en & op2[XLEN-1];
    assign w_mag1   = w_neg1 ? -op1 : op1;
    assign w_mag2   = w_neg2 ? -op2 : op2;
    assign w_div0   = w_is_div && (op2 == '0);
    assign w_ovf    = w_is_div && ~funct3[0] && (op1 == c_int_min) && (op2 == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fa;
    logic [2*XLEN-1:0] w_fb;
    logic [2*XLEN-1:0] w_fast_prod;

    // Sign-extended operands; the low 2*XLEN bits of the product are exact.
    assign w_fa        = {{XLEN{w_neg1}}, op1};
    assign w_fb        = {{XLEN{w_neg2}}, op2};
    assign w_fast_prod = w_fa * w_fb;
`endif

    // One shift-add multiply step: acc = {partial_hi, remaining multiplier bits}.
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_next;
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    // One restoring divide step: acc = {remainder, dividend/quotient}.
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [XLEN-1:0]   w_rem_next;
    logic [2*XLEN-1:0] w_div_next;
    assign w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_rem_next = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_div_next = {w_rem_next, r_acc[XLEN-2:0], ~w_diff[XLEN]};

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_sel;

    always_comb begin
        w_prod = r_acc;
        w_quot = r_acc[XLEN-1:0];
        w_rem  = r_acc[2*XLEN-1:XLEN];
        w_sel  = '0;
        if (!r_nofix) begin
            if (r_neg1 ^ r_neg2) begin
                w_prod = -r_acc;
                w_quot = -r_acc[XLEN-1:0];
            end
            if (r_neg1) begin
                w_rem = -r_acc[2*XLEN-1:XLEN];
            end
        end
        if (r_funct3[2]) begin
            w_sel = r_funct3[1] ? w_rem : w_quot;
        end else begin
            w_sel = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_idle;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_funct3 <= '0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_nofix  <= 1'b0;
            r_cnt    <= '0;
            r_b      <= '0;
            r_acc    <= '0;
        end else if (flush) begin
            r_state <= c_idle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_funct3 <= funct3;
                        r_neg1   <= w_neg1;
                        r_neg2   <= w_neg2;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        if (w_div0) begin
                            r_acc   <= {op1, {XLEN{1'b1}}};
                            r_nofix <= 1'b1;
                            r_state <= c_fix;
                        end else if (w_ovf) begin
                            r_acc   <= {{XLEN{1'b0}}, c_int_min};
                            r_nofix <= 1'b1;
                            r_state <= c_fix;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!w_is_div) begin
                            r_acc   <= w_fast_prod;
                            r_nofix <= 1'b1;
                            r_state <= c_fix;
`endif
                        end else begin
                            r_b     <= w_is_div ? w_mag2 : w_mag1;
                            r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                            r_nofix <= 1'b0;
                            r_state <= c_calc;
                        end
                    end
                end
                c_calc: begin
                    r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= c_fix;
                    end
                end
                c_fix: begin
                    r_result <= w_sel;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= c_done;
                end
                c_done: begin
                    r_done  <= 1'b0;
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Brief    : Self-checking bench for ex_muldiv (vector table + corner sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        flush  = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op1    = '0;
    logic [31:0] op2    = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op1    (op1),
        .op2    (op2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          fast;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents an op so that it is sampled at the next rising edge; returns in cycle 1.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct3 = f;
        op1    = a;
        op2    = b;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        int bad;
        lat = (v.fast || (FAST_MUL && !v.f[2])) ? 2 : 34;
        bad = 0;
        issue(v.f, v.a, v.b);
        for (int k = 1; k <= lat + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (busy !== (k < lat)) bad++;
            if (done !== (k == lat)) bad++;
            if (k == lat) check({name, " result"}, result, v.exp);
        end
        check({name, " timing"}, bad, 0);
    endtask

    initial begin
        int bad;
        vec_t v;

        vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0});
        vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0});
        vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
        vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0});
        vecs.push_back('{3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b1});
        vecs.push_back('{3'b111, 32'd100,      32'd0,        32'd100,      1'b1});
        vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1});
        vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1});
        vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0});
        vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0});
        vecs.push_back('{3'b101, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 1'b0});
        vecs.push_back('{3'b000, 32'd6,        32'd7,        32'd42,       1'b0});
        vecs.push_back('{3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0});
        vecs.push_back('{3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        1'b0});
        vecs.push_back('{3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 1'b0});
        vecs.push_back('{3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{3'b011, 32'h80000000, 32'd2,        32'd1,        1'b0});
        vecs.push_back('{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1});
        vecs.push_back('{3'b111, 32'd1000,     32'd7,        32'd6,        1'b0});

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of CALC (result is nonzero beforehand)
        issue(3'b101, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset done", {31'b0, done}, 32'd0);
        check("midreset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("midreset no done", bad, 0);

        // Flush during DIV keeps the previous result
        v = '{3'b111, 32'd100, 32'd0, 32'd100, 1'b1};
        run_vec(v, "preflush");
        issue(3'b100, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush done", {31'b0, done}, 32'd0);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("flush no done", bad, 0);
        check("flush result kept", result, 32'd100);
        v = '{3'b000, 32'd6, 32'd7, 32'd42, 1'b0};
        run_vec(v, "postflush mul");

        // start held high: one op, operands not re-sampled, re-accept after DONE
        @(negedge clk);
        funct3 = 3'b101;
        op1    = 32'd1000;
        op2    = 32'd10;
        start  = 1'b1;
        @(posedge clk);
        bad = 0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 5) begin
                op1 = 32'd5;
                op2 = 32'd1;
            end
            if (busy !== ((k < 34) || (k == 36))) bad++;
            if (done !== (k == 34)) bad++;
            if (k == 34) check("b2b result", result, 32'd100);
        end
        check("b2b timing", bad, 0);
        start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("b2b flush busy", {31'b0, busy}, 32'd0);

        // flush in IDLE drops a simultaneous start
        @(negedge clk);
        funct3 = 3'b000;
        op1    = 32'd3;
        op2    = 32'd3;
        start  = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        bad = 0;
        repeat (40) begin
            if (busy !== 1'b0 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        check("idle flush drops start", bad, 0);
        check("idle flush result", result, 32'd100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
